// File: rtl/vram_pkg.sv
// vram_pkg: shared screen/VRAM constants and the
// frame-clear sequencer state type.
package vram_pkg;

  localparam int SCREEN_WIDTH  = 800;
  localparam int SCREEN_HEIGHT = 600;
  localparam int VRAM_DEPTH    = SCREEN_WIDTH * SCREEN_HEIGHT;
  localparam int VRAM_A_WIDTH  = 19;
  localparam int VRAM_D_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

endpackage

// File: rtl/vram_clear_seq.sv
// vram_clear_seq: frame-clear FSM and address counter.
// Advances one word per granted slot, pulses done once.
module vram_clear_seq
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_A_WIDTH,
  parameter int DATA_WIDTH = VRAM_D_WIDTH,
  parameter int DEPTH      = VRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  w_rst_n,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_grant,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LP_LAST =
    ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            r_state;
  clr_state_e            w_state_nx;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nx;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_data_nx;

  // State, counter and latched fill value registers
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_data  <= w_data_nx;
    end
  end

  // Next state and status outputs
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_data_nx  = r_data;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nx = CLEAR;
          w_cnt_nx   = '0;
          w_data_nx  = i_data;
        end
      end
      CLEAR: begin
        o_busy = 1'b1;
        if (i_grant) begin
          if (r_cnt == LP_LAST) begin
            w_state_nx = DONE;
          end else begin
            w_cnt_nx = r_cnt + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        o_done     = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign o_addr = r_cnt;
  assign o_data = r_data;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter, display > draw/clear.
// Frame clear built only with VRAM_ARB_CLEAR_EN defined.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_WIDTH = VRAM_A_WIDTH,
  parameter int DATA_WIDTH = VRAM_D_WIDTH,
  parameter int DEPTH      = VRAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  w_rst_n,
  input  logic                  i_disp_en,
  input  logic [ADDR_WIDTH-1:0] i_disp_addr,
  output logic                  o_disp_valid,
  output logic [DATA_WIDTH-1:0] o_disp_data,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_drop,
  input  logic                  i_clr_start,
  input  logic [DATA_WIDTH-1:0] i_clr_data,
  output logic                  o_clr_busy,
  output logic                  o_clr_done,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH =
    (ADDR_WIDTH + 1)'(DEPTH);

  logic                  r_rst_meta;
  logic                  r_run;
  logic                  r_rd_p1;
  logic                  r_rd_p2;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_write;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_wr_drop;

  logic                  w_disp_gnt;
  logic                  w_wr_fire;
  logic                  w_wr_oob;
  logic                  w_clr_gnt;
  logic [ADDR_WIDTH-1:0] w_clr_addr;
  logic [DATA_WIDTH-1:0] w_clr_data;

  // Release reset two edges late so no grant races deassertion
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rst_meta <= 1'b0;
      r_run      <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_run      <= r_rst_meta;
    end
  end

  assign w_disp_gnt = r_run & i_disp_en;
  assign w_wr_fire  = i_wr_valid & o_wr_ready;
  assign w_wr_oob   = {1'b0, i_wr_addr} >= LP_DEPTH;

`ifdef VRAM_ARB_CLEAR_EN
  logic r_last_clr;
  logic w_clr_busy;

  vram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_clr (
    .clk     (clk),
    .w_rst_n (w_rst_n),
    .i_start (i_clr_start & r_run),
    .i_data  (i_clr_data),
    .i_grant (w_clr_gnt),
    .o_addr  (w_clr_addr),
    .o_data  (w_clr_data),
    .o_busy  (w_clr_busy),
    .o_done  (o_clr_done)
  );

  assign o_clr_busy = w_clr_busy;
  assign o_wr_ready = r_run & ~i_disp_en
                    & (~w_clr_busy | r_last_clr);
  assign w_clr_gnt  = r_run & w_clr_busy
                    & ~i_disp_en & ~w_wr_fire;

  // Round-robin memory: which writer got the last slot
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_last_clr <= 1'b1;
    end else if (w_wr_fire) begin
      r_last_clr <= 1'b0;
    end else if (w_clr_gnt) begin
      r_last_clr <= 1'b1;
    end
  end
`else
  logic w_unused_clr;

  assign w_unused_clr = ^{i_clr_start, i_clr_data};
  assign o_clr_busy   = 1'b0;
  assign o_clr_done   = 1'b0;
  assign o_wr_ready   = r_run & ~i_disp_en;
  assign w_clr_gnt    = 1'b0;
  assign w_clr_addr   = '0;
  assign w_clr_data   = '0;
`endif

  // Register the granted access onto the SRAM port
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_mem_addr  <= '0;
      r_mem_write <= 1'b0;
      r_mem_data  <= '0;
      r_wr_drop   <= 1'b0;
    end else begin
      r_mem_write <= 1'b0;
      r_wr_drop   <= 1'b0;
      unique case (1'b1)
        w_disp_gnt: begin
          r_mem_addr <= i_disp_addr;
        end
        w_wr_fire: begin
          if (w_wr_oob) begin
            r_wr_drop <= 1'b1;
          end else begin
            r_mem_addr  <= i_wr_addr;
            r_mem_write <= 1'b1;
            r_mem_data  <= i_wr_data;
          end
        end
        w_clr_gnt: begin
          r_mem_addr  <= w_clr_addr;
          r_mem_write <= 1'b1;
          r_mem_data  <= w_clr_data;
        end
        default: ;
      endcase
    end
  end

  // Track read slots through address and SRAM latency
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_rd_p1 <= 1'b0;
      r_rd_p2 <= 1'b0;
    end else begin
      r_rd_p1 <= w_disp_gnt;
      r_rd_p2 <= r_rd_p1;
    end
  end

  assign o_disp_valid = r_rd_p2;
  assign o_disp_data  = r_rd_p2 ? i_mem_data : '0;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_write  = r_mem_write;
  assign o_mem_data   = r_mem_data;
  assign o_wr_drop    = r_wr_drop;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of vram_arbiter with a
// small SRAM model; clear tests built with VRAM_ARB_CLEAR_EN.
module tb_vram_arbiter;

  localparam int AW  = 8;
  localparam int DW  = 4;
  localparam int DEP = 200;

  logic          clk = 1'b0;
  logic          w_rst_n;
  logic          i_disp_en;
  logic [AW-1:0] i_disp_addr;
  logic          o_disp_valid;
  logic [DW-1:0] o_disp_data;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [AW-1:0] i_wr_addr;
  logic [DW-1:0] i_wr_data;
  logic          o_wr_drop;
  logic          i_clr_start;
  logic [DW-1:0] i_clr_data;
  logic          o_clr_busy;
  logic          o_clr_done;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_write;
  logic [DW-1:0] o_mem_data;
  logic [DW-1:0] i_mem_data;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rd;

  int n_err = 0;
  int n_chk = 0;

  logic [AW-1:0] oob_a [3] = '{8'd199, 8'd200, 8'd255};
  logic          oob_d [3] = '{1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEP)
  ) dut (
    .clk          (clk),
    .w_rst_n      (w_rst_n),
    .i_disp_en    (i_disp_en),
    .i_disp_addr  (i_disp_addr),
    .o_disp_valid (o_disp_valid),
    .o_disp_data  (o_disp_data),
    .i_wr_valid   (i_wr_valid),
    .o_wr_ready   (o_wr_ready),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .o_wr_drop    (o_wr_drop),
    .i_clr_start  (i_clr_start),
    .i_clr_data   (i_clr_data),
    .o_clr_busy   (o_clr_busy),
    .o_clr_done   (o_clr_done),
    .o_mem_addr   (o_mem_addr),
    .o_mem_write  (o_mem_write),
    .o_mem_data   (o_mem_data),
    .i_mem_data   (i_mem_data)
  );

  // single-port synchronous SRAM, one-cycle read latency
  always @(posedge clk) begin
    if (o_mem_write) mem[o_mem_addr] <= o_mem_data;
    r_rd <= mem[o_mem_addr];
  end
  assign i_mem_data = r_rd;

  function automatic logic [DW-1:0] pat(input int a);
    return DW'((a * 7 + 3) % 16);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int nw, bad, done_at, fires, dw, cw, alt_bad;

  initial begin
    for (int a = 0; a < (1 << AW); a++) mem[a] = pat(a);
    w_rst_n = 1'b0; i_disp_en = 1'b0; i_disp_addr = '0;
    i_wr_valid = 1'b0; i_wr_addr = '0; i_wr_data = '0;
    i_clr_start = 1'b0; i_clr_data = '0;
    repeat (3) tick();
    chk("rst_mem_write", o_mem_write, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_disp_valid", o_disp_valid, 0);
    chk("rst_disp_data", o_disp_data, 0);
    chk("rst_wr_ready", o_wr_ready, 0);
    chk("rst_wr_drop", o_wr_drop, 0);
    chk("rst_clr_busy", o_clr_busy, 0);
    chk("rst_clr_done", o_clr_done, 0);

    // release: ready only after the second edge
    w_rst_n = 1'b1; i_wr_valid = 1'b1;
    i_wr_addr = 8'd5; i_wr_data = 4'd9;
    #1 chk("sync_ready_e0", o_wr_ready, 0);
    tick(); chk("sync_ready_e1", o_wr_ready, 0);
    tick(); chk("sync_ready_e2", o_wr_ready, 1);
    chk("sync_nowrite", o_mem_write, 0);
    tick();
    chk("first_wr", o_mem_write, 1);
    chk("first_wr_addr", o_mem_addr, 5);
    chk("first_wr_data", o_mem_data, 9);
    i_wr_valid = 1'b0;
    tick();
    chk("idle_nowrite", o_mem_write, 0);
    chk("idle_addr_hold", o_mem_addr, 5);

    // 40 back-to-back reads at 100..139, valid 2 cycles later
    for (int k = 0; k < 43; k++) begin
      i_disp_en = (k < 40);
      i_disp_addr = AW'(100 + k);
      #1;
      chk("disp_valid", o_disp_valid, (k >= 2 && k < 42));
      if (k >= 2 && k < 42)
        chk("disp_data", o_disp_data, pat(100 + k - 2));
      chk("disp_nowrite", o_mem_write, 0);
      tick();
    end

    // display blocks the draw write
    i_disp_en = 1'b1; i_disp_addr = 8'd10;
    i_wr_valid = 1'b1; i_wr_addr = 8'd50; i_wr_data = 4'd6;
    #1 chk("blk_ready", o_wr_ready, 0);
    tick();
    chk("blk_nowrite", o_mem_write, 0);
    chk("blk_addr", o_mem_addr, 10);
    i_disp_en = 1'b0;
    #1 chk("unblk_ready", o_wr_ready, 1);
    tick();
    chk("unblk_write", o_mem_write, 1);
    chk("unblk_addr", o_mem_addr, 50);
    chk("unblk_data", o_mem_data, 6);
    chk("blk_disp_valid", o_disp_valid, 1);
    chk("blk_disp_data", o_disp_data, pat(10));
    i_wr_valid = 1'b0;
    tick();
    chk("sram_50", mem[50], 6);
    chk("ready_idle", o_wr_ready, 1);

    // range boundary: DEPTH-1 writes, DEPTH and above drop
    for (int i = 0; i < 3; i++) begin
      i_wr_valid = 1'b1; i_wr_addr = oob_a[i]; i_wr_data = 4'hA;
      #1 chk("oob_ready", o_wr_ready, 1);
      tick();
      chk("oob_write", o_mem_write, !oob_d[i]);
      chk("oob_drop", o_wr_drop, oob_d[i]);
      i_wr_valid = 1'b0;
      tick();
      chk("oob_drop_end", o_wr_drop, 0);
    end

    // asynchronous reset kills an in-flight read
    i_disp_en = 1'b1; i_disp_addr = 8'd3;
    tick(); tick();
    chk("pre_rst_valid", o_disp_valid, 1);
    #2 w_rst_n = 1'b0;
    #1;
    chk("arst_valid", o_disp_valid, 0);
    chk("arst_addr", o_mem_addr, 0);
    chk("arst_ready", o_wr_ready, 0);
    i_disp_en = 1'b0;
    tick();
    w_rst_n = 1'b1;
    tick(); tick();
    chk("post_rst_valid", o_disp_valid, 0);

`ifndef VRAM_ARB_CLEAR_EN
    // clear logic absent: start ignored
    i_clr_start = 1'b1; i_clr_data = 4'b1001;
    tick();
    i_clr_start = 1'b0;
    repeat (3) begin
      chk("noclr_busy", o_clr_busy, 0);
      chk("noclr_done", o_clr_done, 0);
      chk("noclr_write", o_mem_write, 0);
      tick();
    end
    i_wr_valid = 1'b1; i_wr_addr = 8'd20; i_wr_data = 4'd3;
    #1 chk("noclr_ready", o_wr_ready, 1);
    tick();
    chk("noclr_draw", o_mem_write, 1);
    i_wr_valid = 1'b0;
    tick();
`else
    // clear alone: DEP writes in order, done at DEP+1
    i_clr_data = 4'b1001; i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0; i_clr_data = 4'b0110;
    chk("clr_busy", o_clr_busy, 1);
    nw = 0; bad = 0; done_at = -1;
    for (int c = 1; c <= DEP + 5; c++) begin
      if (o_mem_write) begin
        if (o_mem_addr != AW'(nw) || o_mem_data != 4'b1001) bad++;
        nw++;
      end
      if (o_clr_done && done_at < 0) done_at = c;
      tick();
    end
    chk("clr_writes", nw, DEP);
    chk("clr_order_bad", bad, 0);
    chk("clr_done_at", done_at, DEP + 1);
    chk("clr_busy_end", o_clr_busy, 0);
    bad = 0;
    for (int a = 0; a < DEP; a++) if (mem[a] != 4'b1001) bad++;
    chk("clr_sram_bad", bad, 0);

    // clear plus draw stream: slots alternate, draw first
    // (last grant of the previous clear run was clear)
    i_clr_data = 4'd3; i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    fires = 0; dw = 0; cw = 0; alt_bad = 0; done_at = -1;
    for (int c = 1; c <= 2 * DEP + 2; c++) begin
      i_wr_valid = (c <= 2 * DEP);
      i_wr_addr = AW'(fires); i_wr_data = 4'd5;
      #1;
      if (i_wr_valid && o_wr_ready) fires++;
      if (o_mem_write) begin
        if (o_mem_data == 4'd5) dw++;
        else cw++;
      end
      if (c >= 2 && c <= 2 * DEP + 1 &&
          !(o_mem_write &&
            o_mem_data == ((c % 2 == 0) ? 4'd5 : 4'd3)))
        alt_bad++;
      if (o_clr_done) done_at = c;
      tick();
    end
    chk("alt_draws_acc", fires, DEP);
    chk("alt_draws_wr", dw, fires);
    chk("alt_clr_wr", cw, DEP);
    chk("alt_pattern_bad", alt_bad, 0);
    chk("alt_done_at", done_at, 2 * DEP + 1);

    // reset mid-clear aborts; restart begins at address 0
    i_clr_data = 4'hF; i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    repeat (50) tick();
    chk("mid_busy_pre", o_clr_busy, 1);
    #2 w_rst_n = 1'b0;
    #1;
    chk("mid_busy", o_clr_busy, 0);
    chk("mid_write", o_mem_write, 0);
    repeat (2) begin
      tick();
      chk("mid_no_done", o_clr_done, 0);
    end
    w_rst_n = 1'b1;
    tick(); tick();
    chk("mid_no_done_rel", o_clr_done, 0);
    i_clr_data = 4'd7; i_clr_start = 1'b1;
    tick();
    i_clr_start = 1'b0;
    tick();
    chk("restart_write", o_mem_write, 1);
    chk("restart_addr", o_mem_addr, 0);
    chk("restart_data", o_mem_data, 7);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
